// File: rtl/hw_bist_pkg.sv
// Shared types, constants and polynomial step helpers for the HelloWorld BIST controller.
package hw_bist_pkg;

    localparam int STIM_W = 6;
    localparam int SIG_W  = 16;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] MISR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An all-zero Fibonacci LFSR never leaves zero, so such a seed is replaced.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                   input logic [STIM_W-1:0] r);
        return {m[SIG_W-2:0], ^(m & MISR_TAPS)} ^ {{(SIG_W-STIM_W){1'b0}}, r};
    endfunction

endpackage

// File: rtl/hw_bist_ctrl_if.sv
// Stimulus/response and status bundle between the BIST controller and its host side.
interface hw_bist_ctrl_if;
    import hw_bist_pkg::*;

    logic              start;
    logic [STIM_W-1:0] resp;
    logic [STIM_W-1:0] stim;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  signature;
    logic [15:0]       pattern_count;

    modport master (
        output start, resp,
        input  stim, busy, done, signature, pattern_count
    );

    modport slave (
        input  start, resp,
        output stim, busy, done, signature, pattern_count
    );

endinterface

// File: rtl/hw_lfsr16.sv
// 16-bit Fibonacci LFSR (shift left, feedback into bit 0) with synchronous load and step enable.
module hw_lfsr16
    import hw_bist_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RESET_VAL;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/hw_bist_ctrl.sv
// BIST controller around the HelloWorld core: LFSR stimulus out, MISR response compaction in.
module hw_bist_ctrl
    import hw_bist_pkg::*;
#(
    parameter int          N_PATTERNS = 256,
    parameter int          PIPE_LAT   = 1,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic     my_clk,
    input  logic     global_reset,
    hw_bist_ctrl_if.slave bist
);

    localparam logic [15:0] SEED_EFF   = seed_fix(LFSR_SEED);
    localparam logic [15:0] LAST_IDX   = 16'(N_PATTERNS - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(PIPE_LAT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_count;
    logic [STIM_W-1:0] r_stim;
    logic [SIG_W-1:0]  r_misr;
    logic [2:0]        r_drain_cnt;
    logic [15:0]       w_lfsr;
    logic              w_start_ok;
    logic              w_run;
    logic              w_run_last;
    logic              w_vld;

    assign w_run = (r_state == RUN);

    hw_lfsr16 #(
        .RESET_VAL (SEED_EFF)
    ) u_lfsr (
        .i_clk   (my_clk),
        .i_rst_n (global_reset),
        .i_load  (w_start_ok),
        .i_en    (w_run),
        .i_seed  (SEED_EFF),
        .o_state (w_lfsr)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_run_last   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bist.start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_count == LAST_IDX) begin
                    w_run_last   = 1'b1;
                    w_state_next = (PIPE_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge my_clk or negedge global_reset) begin
        if (!global_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The LFSR holds the vector shown this cycle; stim is preloaded with the one after it.
    always_ff @(posedge my_clk or negedge global_reset) begin
        if (!global_reset) begin
            r_stim      <= '0;
            r_count     <= '0;
            r_misr      <= '0;
            r_drain_cnt <= '0;
        end else if (w_start_ok) begin
            r_stim      <= SEED_EFF[STIM_W-1:0];
            r_count     <= '0;
            r_misr      <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_run) begin
                r_count <= r_count + 16'd1;
                r_stim  <= w_run_last ? '0 : STIM_W'(lfsr_step(w_lfsr));
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 3'd1;
            end
            if (w_vld) begin
                r_misr <= misr_step(r_misr, bist.resp);
            end
        end
    end

    // Issue marks travel alongside the core pipeline so each response is compacted exactly once.
    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign w_vld = w_run;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] r_vpipe;

            always_ff @(posedge my_clk or negedge global_reset) begin
                if (!global_reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe[0] <= w_run;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        r_vpipe[i] <= r_vpipe[i-1];
                    end
                end
            end

            assign w_vld = r_vpipe[PIPE_LAT-1];
        end
    endgenerate

    assign bist.stim          = r_stim;
    assign bist.busy          = (r_state == RUN) || (r_state == DRAIN);
    assign bist.done          = (r_state == DONE);
    assign bist.signature     = r_misr;
    assign bist.pattern_count = r_count;

endmodule

// File: tb/tb_hw_bist_ctrl.sv
// Self-checking bench for hw_bist_ctrl: four parameterisations driven from directed sequences.
module tb_hw_bist_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int t0       = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    hw_bist_ctrl_if if_a ();
    hw_bist_ctrl_if if_b ();
    hw_bist_ctrl_if if_c ();
    hw_bist_ctrl_if if_d ();

    hw_bist_ctrl #(.N_PATTERNS(256),  .PIPE_LAT(1)) u_a (.my_clk(clk), .global_reset(rst_n), .bist(if_a.slave));
    hw_bist_ctrl #(.N_PATTERNS(1),    .PIPE_LAT(0)) u_b (.my_clk(clk), .global_reset(rst_n), .bist(if_b.slave));
    hw_bist_ctrl #(.N_PATTERNS(1000), .PIPE_LAT(3)) u_c (.my_clk(clk), .global_reset(rst_n), .bist(if_c.slave));
    hw_bist_ctrl #(.N_PATTERNS(2),    .PIPE_LAT(0), .LFSR_SEED(16'h0000))
        u_d (.my_clk(clk), .global_reset(rst_n), .bist(if_d.slave));

    // Instance A: zero response, or loopback of stim delayed one cycle.
    logic       loop_mode = 1'b0;
    logic [5:0] loop_q;
    always @(posedge clk) loop_q <= if_a.stim;
    assign if_a.resp = loop_mode ? loop_q : 6'd0;

    // Instance C: behavioural core = random lookup followed by three pipeline stages.
    logic [5:0] core_tbl [64];
    logic [5:0] c_p0, c_p1, c_p2;
    always @(posedge clk) begin
        c_p0 <= core_tbl[if_c.stim];
        c_p1 <= c_p0;
        c_p2 <= c_p1;
    end
    assign if_c.resp = c_p2;
    assign if_d.resp = 6'd0;

    typedef struct {
        logic        start;
        logic [5:0]  exp_stim;
        logic        exp_busy;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] m_lfsr(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [5:0] r);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int idx);
        case (idx)
            0:       return if_a.done;
            1:       return if_b.done;
            2:       return if_c.done;
            default: return if_d.done;
        endcase
    endfunction

    task automatic set_start(input int idx, input logic v);
        case (idx)
            0:       if_a.start = v;
            1:       if_b.start = v;
            2:       if_c.start = v;
            default: if_d.start = v;
        endcase
    endtask

    // Leaves the bench at the negedge inside RUN cycle 0.
    task automatic start_pulse(input int idx);
        @(negedge clk);
        set_start(idx, 1'b1);
        t0 = edge_cnt;
        @(negedge clk);
        set_start(idx, 1'b0);
    endtask

    task automatic wait_done(input int idx, input int budget, input string name, output int lat);
        int n = 0;
        while (!done_of(idx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done_of(idx)}, 32'd1);
        lat = edge_cnt - t0;
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] sig_loop;
        logic [15:0] sig_core;
        logic [15:0] sig_run1;
        int          lat;
        int          n;

        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;
        if_d.start = 1'b0;
        if_b.resp  = 6'd0;
        for (int i = 0; i < 64; i++) core_tbl[i] = 6'($urandom);

        vecs[0] = '{start: 1'b0, exp_stim: 6'h21, exp_busy: 1'b1, exp_count: 16'd0};
        vecs[1] = '{start: 1'b1, exp_stim: 6'h03, exp_busy: 1'b1, exp_count: 16'd1};
        vecs[2] = '{start: 1'b0, exp_stim: 6'h07, exp_busy: 1'b1, exp_count: 16'd2};
        vecs[3] = '{start: 1'b1, exp_stim: 6'h0F, exp_busy: 1'b1, exp_count: 16'd3};
        vecs[4] = '{start: 1'b0, exp_stim: 6'h1E, exp_busy: 1'b1, exp_count: 16'd4};
        vecs[5] = '{start: 1'b0, exp_stim: 6'h3C, exp_busy: 1'b1, exp_count: 16'd5};

        l = 16'hACE1;
        sig_loop = 16'h0000;
        for (int k = 0; k < 256; k++) begin
            sig_loop = m_misr(sig_loop, l[5:0]);
            l = m_lfsr(l);
        end
        l = 16'hACE1;
        sig_core = 16'h0000;
        for (int k = 0; k < 1000; k++) begin
            sig_core = m_misr(sig_core, core_tbl[l[5:0]]);
            l = m_lfsr(l);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst stim",  {26'd0, if_a.stim}, 32'd0);
        check("rst busy",  {31'd0, if_a.busy}, 32'd0);
        check("rst done",  {31'd0, if_a.done}, 32'd0);
        check("rst sig",   {16'd0, if_a.signature}, 32'd0);
        check("rst count", {16'd0, if_a.pattern_count}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle busy", {31'd0, if_a.busy}, 32'd0);
        check("idle stim", {26'd0, if_a.stim}, 32'd0);

        // First vectors from the default seed; start pulses mid-run must be ignored
        start_pulse(0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("vec%0d stim", i),  {26'd0, if_a.stim}, {26'd0, vecs[i].exp_stim});
            check($sformatf("vec%0d busy", i),  {31'd0, if_a.busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d count", i), {16'd0, if_a.pattern_count}, {16'd0, vecs[i].exp_count});
            if_a.start = vecs[i].start;
            @(negedge clk);
        end
        if_a.start = 1'b0;
        wait_done(0, 400, "zero done", lat);
        check("zero latency", lat, 32'd258);
        check("zero sig",     {16'd0, if_a.signature}, 32'd0);
        check("zero count",   {16'd0, if_a.pattern_count}, 32'd256);
        check("zero busy",    {31'd0, if_a.busy}, 32'd0);
        check("zero stim",    {26'd0, if_a.stim}, 32'd0);

        // Loopback run with a start during RUN
        loop_mode = 1'b1;
        start_pulse(0);
        repeat (10) @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        wait_done(0, 400, "loop1 done", lat);
        check("loop1 latency", lat, 32'd258);
        check("loop1 count",   {16'd0, if_a.pattern_count}, 32'd256);
        check("loop1 sig",     {16'd0, if_a.signature}, {16'd0, sig_loop});
        sig_run1 = if_a.signature;

        // Rerun from DONE, with a start on the edge that enters DONE
        start_pulse(0);
        check("loop2 busy",  {31'd0, if_a.busy}, 32'd1);
        check("loop2 done",  {31'd0, if_a.done}, 32'd0);
        check("loop2 count", {16'd0, if_a.pattern_count}, 32'd0);
        check("loop2 stim",  {26'd0, if_a.stim}, 32'd33);
        n = 0;
        while ((edge_cnt - t0) < 257 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("loop2 drain busy", {31'd0, if_a.busy}, 32'd1);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        check("loop2 done edge",   {31'd0, if_a.done}, 32'd1);
        check("loop2 busy edge",   {31'd0, if_a.busy}, 32'd0);
        check("loop2 sig repeat",  {16'd0, if_a.signature}, {16'd0, sig_run1});
        @(negedge clk);
        check("loop2 start ignored", {31'd0, if_a.done}, 32'd1);
        check("loop2 sig held",      {16'd0, if_a.signature}, {16'd0, sig_loop});

        // PIPE_LAT=0, N=1: response only valid during the single RUN cycle
        @(negedge clk);
        if_b.start = 1'b1;
        t0 = edge_cnt;
        @(posedge clk);
        #1;
        if_b.start = 1'b0;
        if_b.resp  = 6'h01;
        @(negedge clk);
        check("lat0 stim", {26'd0, if_b.stim}, 32'h21);
        check("lat0 busy", {31'd0, if_b.busy}, 32'd1);
        @(posedge clk);
        #1;
        if_b.resp = 6'h00;
        @(negedge clk);
        check("lat0 done",    {31'd0, if_b.done}, 32'd1);
        check("lat0 latency", edge_cnt - t0, 32'd2);
        check("lat0 sig",     {16'd0, if_b.signature}, 32'h0001);
        check("lat0 count",   {16'd0, if_b.pattern_count}, 32'd1);

        // Golden model: N=1000, PIPE_LAT=3
        start_pulse(2);
        wait_done(2, 1100, "core done", lat);
        check("core latency", lat, 32'd1004);
        check("core count",   {16'd0, if_c.pattern_count}, 32'd1000);
        check("core sig",     {16'd0, if_c.signature}, {16'd0, sig_core});

        // Zero seed becomes 16'h0001
        start_pulse(3);
        check("seed0 stim0", {26'd0, if_d.stim}, 32'h01);
        @(negedge clk);
        check("seed0 stim1", {26'd0, if_d.stim}, 32'h02);
        wait_done(3, 20, "seed0 done", lat);
        check("seed0 latency", lat, 32'd3);
        check("seed0 count",   {16'd0, if_d.pattern_count}, 32'd2);

        // Asynchronous reset mid-run
        start_pulse(0);
        repeat (20) @(negedge clk);
        check("mid busy", {31'd0, if_a.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async stim",  {26'd0, if_a.stim}, 32'd0);
        check("async busy",  {31'd0, if_a.busy}, 32'd0);
        check("async done",  {31'd0, if_a.done}, 32'd0);
        check("async sig",   {16'd0, if_a.signature}, 32'd0);
        check("async count", {16'd0, if_a.pattern_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post busy",  {31'd0, if_a.busy}, 32'd0);
        check("post done",  {31'd0, if_a.done}, 32'd0);
        check("post count", {16'd0, if_a.pattern_count}, 32'd0);
        check("post stim",  {26'd0, if_a.stim}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
